// File: rtl/frame_config_mem_shadow.sv
// Tile configuration memory with a shadow frame store, per-frame parity and dirty tracking,
// atomic commit into the active store, and registered readback of either store.
module frame_config_mem_shadow #(
    parameter int MaxFramesPerCol  = 20,
    parameter int FrameBitsPerRow  = 32,
    parameter int NoConfigBits     = MaxFramesPerCol * FrameBitsPerRow,
    parameter bit RequireAllFrames = 1'b0,
    localparam int FW = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [FrameBitsPerRow-1:0] FrameData,
    input  logic [MaxFramesPerCol-1:0] FrameStrobe,
    input  logic                       FrameParity,
    input  logic                       Commit,
    input  logic                       ClearErr,
    input  logic [FW-1:0]              RbSel,
    input  logic                       RbSrc,
    output logic [FrameBitsPerRow-1:0] RbData,
    output logic [NoConfigBits-1:0]    ConfigBits,
    output logic [NoConfigBits-1:0]    ConfigBits_N,
    output logic [MaxFramesPerCol-1:0] Dirty,
    output logic                       Busy,
    output logic                       Error,
    output logic [1:0]                 ErrCode,
    output logic [FW-1:0]              ErrFrame,
    output logic                       CommitDone
);

    localparam int TotalBits = MaxFramesPerCol * FrameBitsPerRow;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE       = 2'd0,
        ERR_PARITY     = 2'd1,
        ERR_MULTI_HOT  = 2'd2,
        ERR_INCOMPLETE = 2'd3
    } err_code_t;

    state_t state, state_next;

    logic [MaxFramesPerCol-1:0][FrameBitsPerRow-1:0] shadow;
    logic [MaxFramesPerCol-1:0][FrameBitsPerRow-1:0] active;
    logic [TotalBits-1:0]                            active_flat;

    logic [MaxFramesPerCol-1:0] dirty, dirty_next;
    err_code_t                  err_code, err_code_next;
    logic [FW-1:0]              err_frame, err_frame_next;
    logic                       commit_done, commit_done_next;
    logic [FrameBitsPerRow-1:0] rb_data, rb_next;

    logic          in_error;
    logic          strobe_any;
    logic          strobe_onehot;
    logic          parity_ok;
    logic [FW-1:0] frame_idx;
    logic          wr_en;
    logic          wr_par_err;
    logic          wr_multi_err;
    logic          commit_req;
    logic          commit_incomplete;
    logic          commit_copy;

    // ------------------------------------------------------------------
    // Write/commit decode
    // ------------------------------------------------------------------
    assign in_error      = (state == ST_ERROR);
    assign strobe_any    = |FrameStrobe;
    assign strobe_onehot = strobe_any && ((FrameStrobe & (FrameStrobe - 1'b1)) == '0);
    assign parity_ok     = ~(^{FrameData, FrameParity});

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        frame_idx = '0;
        for (int f = 0; f < MaxFramesPerCol; f++) begin
            if (FrameStrobe[f]) frame_idx = FW'(f);
        end
    end

    assign wr_en        = !in_error && strobe_onehot && parity_ok;
    assign wr_par_err   = !in_error && strobe_onehot && !parity_ok;
    assign wr_multi_err = !in_error && strobe_any && !strobe_onehot;

    // A write error in the same cycle suppresses the commit.
    assign commit_req        = !in_error && Commit && !wr_par_err && !wr_multi_err;
    assign commit_incomplete = commit_req && (state == ST_LOADED) && RequireAllFrames && !(&dirty);
    assign commit_copy       = commit_req && (state == ST_LOADED) && !commit_incomplete;

    // ------------------------------------------------------------------
    // Next-state, dirty and error bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state;
        dirty_next       = dirty;
        err_code_next    = err_code;
        err_frame_next   = err_frame;
        commit_done_next = 1'b0;

        if (in_error) begin
            if (ClearErr) begin
                err_code_next  = ERR_NONE;
                err_frame_next = '0;
                state_next     = (dirty != '0) ? ST_LOADED : ST_IDLE;
            end
        end else if (wr_par_err) begin
            err_code_next  = ERR_PARITY;
            err_frame_next = frame_idx;
            state_next     = ST_ERROR;
        end else if (wr_multi_err) begin
            err_code_next  = ERR_MULTI_HOT;
            err_frame_next = '0;
            state_next     = ST_ERROR;
        end else if (commit_incomplete) begin
            err_code_next  = ERR_INCOMPLETE;
            err_frame_next = '0;
            state_next     = ST_ERROR;
        end else begin
            // Commit clears dirty first so a simultaneous write stays dirty.
            if (commit_copy) dirty_next = '0;
            if (wr_en) dirty_next[frame_idx] = 1'b1;
            commit_done_next = commit_req;
            state_next       = (dirty_next != '0) ? ST_LOADED : ST_IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            dirty       <= '0;
            err_code    <= ERR_NONE;
            err_frame   <= '0;
            commit_done <= 1'b0;
        end else begin
            state       <= state_next;
            dirty       <= dirty_next;
            err_code    <= err_code_next;
            err_frame   <= err_frame_next;
            commit_done <= commit_done_next;
        end
    end

    // ------------------------------------------------------------------
    // Frame stores
    // ------------------------------------------------------------------
    // NOTE: both stores are flip-flops with a reset because live config bits must be
    // known-zero out of reset; this is register storage, not an inferable RAM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shadow <= '0;
        end else if (wr_en) begin
            shadow[frame_idx] <= FrameData;
        end
    end

    // The commit copies the pre-write shadow because both blocks sample it before the edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            active <= '0;
        end else if (commit_copy) begin
            active <= shadow;
        end
    end

    // ------------------------------------------------------------------
    // Readback
    // ------------------------------------------------------------------
    always_comb begin
        rb_next = '0;
        if (int'(RbSel) < MaxFramesPerCol) begin
            rb_next = RbSrc ? shadow[RbSel] : active[RbSel];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rb_data <= '0;
        end else begin
            rb_data <= rb_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign active_flat  = active;
    assign ConfigBits   = active_flat[NoConfigBits-1:0];
    assign ConfigBits_N = ~ConfigBits;
    assign Dirty        = dirty;
    assign Busy         = in_error;
    assign Error        = in_error;
    assign ErrCode      = err_code;
    assign ErrFrame     = err_frame;
    assign CommitDone   = commit_done;
    assign RbData       = rb_data;

endmodule

// File: tb/tb_frame_config_mem_shadow.sv
// Directed bench for frame_config_mem_shadow: one instance with RequireAllFrames=0 and one with
// RequireAllFrames=1 share stimulus; readback results are checked through a scoreboard queue.
module tb_frame_config_mem_shadow;

    localparam int NF = 20;
    localparam int NB = 32;
    localparam int NC = 640;
    localparam int FW = 5;

    logic          CLK;
    logic          RST;
    logic [NB-1:0] FrameData;
    logic [NF-1:0] FrameStrobe;
    logic          FrameParity;
    logic          Commit;
    logic          ClearErr;
    logic [FW-1:0] RbSel;
    logic          RbSrc;

    logic [NB-1:0] rb_data_a, rb_data_b;
    logic [NC-1:0] cfg_a, cfg_b, cfg_n_a, cfg_n_b;
    logic [NF-1:0] dirty_a, dirty_b;
    logic          busy_a, busy_b, error_a, error_b, done_a, done_b;
    logic [1:0]    code_a, code_b;
    logic [FW-1:0] frame_a, frame_b;

    frame_config_mem_shadow #(
        .MaxFramesPerCol(NF), .FrameBitsPerRow(NB), .NoConfigBits(NC), .RequireAllFrames(1'b0)
    ) dut (
        .CLK(CLK), .RST(RST), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .FrameParity(FrameParity), .Commit(Commit), .ClearErr(ClearErr),
        .RbSel(RbSel), .RbSrc(RbSrc), .RbData(rb_data_a), .ConfigBits(cfg_a),
        .ConfigBits_N(cfg_n_a), .Dirty(dirty_a), .Busy(busy_a), .Error(error_a),
        .ErrCode(code_a), .ErrFrame(frame_a), .CommitDone(done_a)
    );

    frame_config_mem_shadow #(
        .MaxFramesPerCol(NF), .FrameBitsPerRow(NB), .NoConfigBits(NC), .RequireAllFrames(1'b1)
    ) dut_raf (
        .CLK(CLK), .RST(RST), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
        .FrameParity(FrameParity), .Commit(Commit), .ClearErr(ClearErr),
        .RbSel(RbSel), .RbSrc(RbSrc), .RbData(rb_data_b), .ConfigBits(cfg_b),
        .ConfigBits_N(cfg_n_b), .Dirty(dirty_b), .Busy(busy_b), .Error(error_b),
        .ErrCode(code_b), .ErrFrame(frame_b), .CommitDone(done_b)
    );

    typedef struct {
        string       tag;
        logic [NB-1:0] val;
    } rb_exp_t;

    rb_exp_t rb_q[$];
    int      n_total  = 0;
    int      n_passed = 0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [NC-1:0] obs, input logic [NC-1:0] exp);
        n_total++;
        assert (obs === exp) n_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        FrameStrobe = '0;
        FrameData   = '0;
        FrameParity = 1'b0;
        Commit      = 1'b0;
        ClearErr    = 1'b0;
    endtask

    // Advance one edge, settle, then retire any pending readback expectation.
    task automatic tick();
        rb_exp_t e;
        @(posedge CLK);
        #1;
        if (rb_q.size() > 0) begin
            e = rb_q.pop_front();
            check(e.tag, {{(NC-NB){1'b0}}, rb_data_a}, {{(NC-NB){1'b0}}, e.val});
        end
    endtask

    task automatic wr(input int f, input logic [NB-1:0] d, input logic par);
        FrameData   = d;
        FrameStrobe = NF'(1) << f;
        FrameParity = par;
    endtask

    task automatic rb(input string tag, input logic [FW-1:0] sel, input logic src,
                      input logic [NB-1:0] exp);
        rb_exp_t e;
        RbSel = sel;
        RbSrc = src;
        e.tag = tag;
        e.val = exp;
        rb_q.push_back(e);
    endtask

    logic [NC-1:0] exp_cfg;
    logic [NB-1:0] d, x_val, y_val;

    initial begin
        RST   = 1'b1;
        RbSel = '0;
        RbSrc = 1'b0;
        idle_inputs();

        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check("rst_cfg",    cfg_a,   '0);
        check("rst_cfg_n",  cfg_n_a, {NC{1'b1}});
        check("rst_dirty",  dirty_a, '0);
        check("rst_error",  error_a, '0);
        check("rst_busy",   busy_a,  '0);
        check("rst_rbdata", rb_data_a, '0);
        check("rst_done",   done_a,  '0);
        RST = 1'b0;
        tick();

        // Write frame 3 then commit
        wr(3, 32'hA5A5_0001, 1'b1);
        tick();
        idle_inputs();
        check("wr3_dirty", dirty_a, 20'h00008);
        rb("rb_active3_pre", 5'd3, 1'b0, 32'h0);
        tick();
        rb("rb_shadow3_pre", 5'd3, 1'b1, 32'hA5A5_0001);
        tick();
        Commit = 1'b1;
        tick();
        Commit = 1'b0;
        check("commit_done",  done_a, 1'b1);
        check("commit_frame3", cfg_a[127:96], 32'hA5A5_0001);
        check("commit_dirty", dirty_a, '0);
        check("commit_cfg_n", cfg_n_a[127:96], 32'h5A5A_FFFE);
        rb("rb_active3_post", 5'd3, 1'b0, 32'hA5A5_0001);
        tick();
        check("done_one_cycle", done_a, 1'b0);
        rb("rb_out_of_range", 5'd25, 1'b1, 32'h0);
        tick();

        // Parity error on frame 7, commit ignored, then clear
        wr(7, 32'h0000_0001, 1'b0);
        tick();
        idle_inputs();
        check("par_error", error_a, 1'b1);
        check("par_busy",  busy_a,  1'b1);
        check("par_code",  code_a,  2'd1);
        check("par_frame", frame_a, 5'd7);
        check("par_dirty", dirty_a, '0);
        Commit = 1'b1;
        rb("rb_shadow7_par", 5'd7, 1'b1, 32'h0);
        tick();
        Commit = 1'b0;
        check("err_commit_ignored", done_a, 1'b0);
        check("err_cfg_kept", cfg_a[127:96], 32'hA5A5_0001);
        ClearErr = 1'b1;
        tick();
        ClearErr = 1'b0;
        check("clr_error", error_a, 1'b0);
        check("clr_code",  code_a,  2'd0);
        check("clr_frame", frame_a, 5'd0);
        check("clr_idle_dirty", dirty_a, '0);

        // Multi-hot strobe, second error does not overwrite the first
        FrameStrobe = 20'h00003;
        FrameData   = 32'h0000_0003;
        FrameParity = 1'b0;
        tick();
        idle_inputs();
        check("multi_code",  code_a,  2'd2);
        check("multi_frame", frame_a, 5'd0);
        check("multi_dirty", dirty_a, '0);
        wr(5, 32'h0000_0001, 1'b0);
        rb("rb_shadow0_multi", 5'd0, 1'b1, 32'h0);
        tick();
        idle_inputs();
        check("sticky_code",  code_a,  2'd2);
        check("sticky_frame", frame_a, 5'd0);
        rb("rb_shadow1_multi", 5'd1, 1'b1, 32'h0);
        ClearErr = 1'b1;
        tick();
        ClearErr = 1'b0;
        check("multi_clr", error_a, 1'b0);

        // RequireAllFrames: async reset, load frames 0..18, commit must fail on dut_raf
        #2 RST = 1'b1;
        #1;
        check("raf_rst_cfg",  cfg_b, '0);
        check("rst2_cfg_a",   cfg_a, '0);
        RST = 1'b0;
        exp_cfg = '0;
        for (int f = 0; f < NF - 1; f++) begin
            d = 32'h1000_0000 + NB'(f);
            exp_cfg[f*NB +: NB] = d;
            wr(f, d, ^d);
            tick();
        end
        idle_inputs();
        check("raf_dirty19", dirty_b, 20'h7FFFF);
        Commit = 1'b1;
        tick();
        Commit = 1'b0;
        check("raf_code3",  code_b,  2'd3);
        check("raf_error",  error_b, 1'b1);
        check("raf_nodone", done_b,  1'b0);
        check("raf_cfg_unchanged", cfg_b, '0);
        check("norm_commit_done", done_a, 1'b1);
        ClearErr = 1'b1;
        tick();
        ClearErr = 1'b0;
        check("raf_clr", error_b, 1'b0);
        check("raf_dirty_kept", dirty_b, 20'h7FFFF);
        d = 32'h1000_0013;
        exp_cfg[19*NB +: NB] = d;
        wr(19, d, ^d);
        tick();
        idle_inputs();
        Commit = 1'b1;
        tick();
        Commit = 1'b0;
        check("raf_all_cfg",   cfg_b,   exp_cfg);
        check("raf_all_done",  done_b,  1'b1);
        check("raf_all_dirty", dirty_b, '0);

        // Same-cycle write and commit
        x_val = 32'hCAFE_0002;
        y_val = 32'h1234_5678;
        wr(2, x_val, ^x_val);
        tick();
        wr(2, y_val, ^y_val);
        Commit = 1'b1;
        tick();
        idle_inputs();
        check("wc_done",   done_a,  1'b1);
        check("wc_active", cfg_a[95:64], x_val);
        check("wc_dirty",  dirty_a, 20'h00004);
        rb("wc_rb_shadow", 5'd2, 1'b1, y_val);
        tick();
        rb("wc_rb_active", 5'd2, 1'b0, x_val);
        tick();

        // Async reset in the middle of a load
        wr(4, 32'h0000_0007, 1'b1);
        RbSel = 5'd2;
        RbSrc = 1'b1;
        tick();
        idle_inputs();
        #3 RST = 1'b1;
        #1;
        check("mid_rst_cfg",    cfg_a,     '0);
        check("mid_rst_cfg_n",  cfg_n_a,   {NC{1'b1}});
        check("mid_rst_dirty",  dirty_a,   '0);
        check("mid_rst_rbdata", rb_data_a, '0);
        check("mid_rst_error",  error_a,   '0);
        #2 RST = 1'b0;
        rb("mid_rst_shadow2", 5'd2, 1'b1, 32'h0);
        tick();
        rb("mid_rst_shadow4", 5'd4, 1'b1, 32'h0);
        tick();

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/frame_config_mem_shadow.md
Name: frame_config_mem_shadow

Overview:
- Parametrised, clocked successor to the tile frame-latch configuration memory.
- Frames are written into a shadow store with per-frame parity checking and dirty tracking.
- A commit command copies the shadow store atomically into the active configuration that drives the tile's switch matrix and BELs.
- Active and shadow frames can be read back, which enables partial reconfiguration without glitching live configuration bits.

Parameters:
- MaxFramesPerCol, 20, number of frames (strobe lines) per tile.
- FrameBitsPerRow, 32, bits per frame.
- NoConfigBits, 640, configuration bits exported. Must satisfy 1 <= NoConfigBits <= MaxFramesPerCol*FrameBitsPerRow.
- RequireAllFrames, 0, if 1 a commit is legal only when every frame is dirty.

Ports:
- CLK  in  1  configuration clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- FrameData  in  FrameBitsPerRow  frame payload.
- FrameStrobe  in  MaxFramesPerCol  one-hot frame select; all-zero means no write.
- FrameParity  in  1  even parity of FrameData (XOR of FrameData ^ FrameParity must be 0).
- Commit  in  1  single-cycle commit request.
- ClearErr  in  1  single-cycle error clear.
- RbSel  in  FW  readback frame index, FW = $clog2(MaxFramesPerCol).
- RbSrc  in  1  0 = read active store, 1 = read shadow store.
- RbData  out  FrameBitsPerRow  readback data.
- ConfigBits  out  NoConfigBits  active configuration.
- ConfigBits_N  out  NoConfigBits  bitwise inverse of ConfigBits.
- Dirty  out  MaxFramesPerCol  per-frame "written since last commit" flags.
- Busy  out  1  high in state ERROR (writes blocked).
- Error  out  1  sticky error flag.
- ErrCode  out  2  error code: 0 none, 1 parity, 2 multi-hot strobe, 3 incomplete commit.
- ErrFrame  out  FW  frame index of the first error (0 for codes 2 and 3).
- CommitDone  out  1  one-cycle pulse, registered.

Behaviour:
- Bit mapping: active/shadow bit [f*FrameBitsPerRow + b] is frame f, bit b. Bits at index >= NoConfigBits are stored but not exported.
- Reset (async, RST=1):
  - active and shadow stores cleared to 0; ConfigBits=0, ConfigBits_N all ones.
  - Dirty=0, Error=0, ErrCode=0, ErrFrame=0, CommitDone=0, RbData=0, Busy=0.
  - State returns to IDLE.
  - Reset mid-load discards all shadow contents.
- States:
  - IDLE: Dirty==0.
  - LOADED: Dirty!=0.
  - ERROR: Error==1.
- Write, accepted only in IDLE/LOADED when FrameStrobe!=0:
  - Exactly one bit f set with correct parity: shadow[f] <= FrameData, Dirty[f] <= 1, next state LOADED. Rewriting an already-dirty frame overwrites it.
  - Parity mismatch: no write; Error=1, ErrCode=1, ErrFrame=f; go to ERROR.
  - More than one strobe bit set: no write; Error=1, ErrCode=2, ErrFrame=0; go to ERROR.
- Commit:
  - In IDLE: no store change; CommitDone pulses next cycle.
  - In LOADED with RequireAllFrames=1 and Dirty not all ones: Error=1, ErrCode=3; go to ERROR; active unchanged.
  - Otherwise: active <= shadow (all frames, one cycle); Dirty <= 0; CommitDone=1 next cycle; go to IDLE. ConfigBits change exactly one cycle after Commit is sampled, with no intermediate values.
- Simultaneous write + commit in the same cycle:
  - The commit copies the pre-write shadow.
  - The write still lands in shadow and Dirty[f] ends at 1, so the state ends LOADED.
  - Error checks on the write still apply. On a write error, the commit is suppressed.
- ERROR state:
  - Writes and Commit are ignored (no store change, no CommitDone).
  - ClearErr clears Error, ErrCode and ErrFrame; shadow and Dirty are kept; next state is LOADED if Dirty!=0, else IDLE.
  - ClearErr takes priority: any write or commit in the same cycle is ignored.
  - Only the first error is recorded until cleared.
- Readback:
  - RbData is registered, with 1-cycle latency, from the store chosen by RbSrc at index RbSel.
  - RbSel >= MaxFramesPerCol gives 0.
  - Readback is legal in every state and never affects state.
- ConfigBits_N is combinationally ~ConfigBits at all times.

Test Plan:
- Reset then idle: RST pulse → ConfigBits=0, ConfigBits_N=640'h all ones, Dirty=0, Error=0, RbData=0.
- Write and commit: write frame 3 = 32'hA5A5_0001 (FrameParity=1), then Commit → ConfigBits[127:96]=32'hA5A5_0001 one cycle after Commit, CommitDone pulse, Dirty=0. The pre-commit readback with RbSrc=0 returns 0; with RbSrc=1 it returns 32'hA5A5_0001.
- Parity error: write frame 7 = 32'h0000_0001 with FrameParity=0 → shadow unchanged, Error=1, ErrCode=1, ErrFrame=7. A following Commit is ignored. ClearErr → Error=0, state IDLE.
- Multi-hot strobe: FrameStrobe=20'h00003 → no write, ErrCode=2. A second error (parity, frame 5) before ClearErr leaves ErrCode=2, ErrFrame=0.
- RequireAllFrames=1: write frames 0–18 only, then Commit → ErrCode=3, ConfigBits unchanged. ClearErr, write frame 19, Commit → all 20 frames active.
- Same-cycle write + commit: frame 2 dirty with X, then write frame 2 = Y together with Commit → active frame 2 = X, shadow frame 2 = Y, Dirty[2]=1, CommitDone=1. Async RST asserted mid-sequence → all outputs return to reset values immediately.
